// File: rtl/demo_serial_transmitter.sv
// Serial transmitter for the demo board-to-board link: start bit, LSB-first data,
// optional even parity, stop bit; every line value is held CLKS_PER_BIT clocks.
module demo_serial_transmitter #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_serial,
    output logic                 busy,
    output logic                 complete,
    output logic [4:0]           bit_count
);

    localparam int               DIV_W      = $clog2(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]       COUNT_LAST = 5'(DATA_BITS - 1);
    localparam logic [4:0]       COUNT_FULL = 5'(DATA_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_reg, state_next;
    logic [DIV_W-1:0]     div_reg, div_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic                 parity_reg, parity_next;
    logic [4:0]           count_reg, count_next;
    logic                 tx_serial_next, tx_ready_next, busy_next, complete_next;
    logic                 accept, div_last;

    assign accept    = tx_valid && (state_reg == S_IDLE);
    assign div_last  = (div_reg == DIV_LAST);
    assign bit_count = count_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= S_IDLE;
            div_reg    <= '0;
            shift_reg  <= '0;
            parity_reg <= 1'b0;
            count_reg  <= '0;
            tx_serial  <= 1'b1;
            tx_ready   <= 1'b1;
            busy       <= 1'b0;
            complete   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            div_reg    <= div_next;
            shift_reg  <= shift_next;
            parity_reg <= parity_next;
            count_reg  <= count_next;
            tx_serial  <= tx_serial_next;
            tx_ready   <= tx_ready_next;
            busy       <= busy_next;
            complete   <= complete_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (accept) state_next = S_START;
            S_START:  if (div_last) state_next = S_DATA;
            S_DATA: begin
                if (div_last && (count_reg == COUNT_LAST))
                    state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (div_last) state_next = S_STOP;
            S_STOP:   if (div_last) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values; the line value is derived from
    // the state being entered so it lines up with the state register.
    always_comb begin
        div_next    = (state_reg == S_IDLE || div_last) ? '0 : div_reg + 1'b1;
        shift_next  = shift_reg;
        parity_next = parity_reg;
        count_next  = count_reg;

        if (accept) begin
            shift_next  = tx_data;
            parity_next = ^tx_data;
            count_next  = '0;
        end else if (state_reg == S_DATA && div_last) begin
            shift_next = shift_reg >> 1;
            if (count_reg != COUNT_FULL)
                count_next = count_reg + 5'd1;
        end

        case (state_next)
            S_START:  tx_serial_next = 1'b0;
            S_DATA:   tx_serial_next = shift_next[0];
            S_PARITY: tx_serial_next = parity_reg;
            default:  tx_serial_next = 1'b1;
        endcase

        tx_ready_next = (state_next == S_IDLE);
        busy_next     = (state_next != S_IDLE);
        complete_next = (state_reg == S_STOP) && div_last;
    end

endmodule

// File: tb/tb_demo_serial_transmitter.sv
// Directed bench: one parity-enabled and one parity-free transmitter, CLKS_PER_BIT=4,
// checking the line every clock against hand-written frame bit patterns.
module tb_demo_serial_transmitter;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_p = 1'b0;
    logic       valid_np = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sel = 1'b0;

    logic       ready_p, serial_p, busy_p, complete_p;
    logic       ready_np, serial_np, busy_np, complete_np;
    logic [4:0] count_p, count_np;
    logic       o_ready, o_serial, o_busy, o_complete;
    logic [4:0] o_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    demo_serial_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(1)) dut_p (
        .clk(clk), .reset(reset), .tx_valid(valid_p), .tx_data(tx_data),
        .tx_ready(ready_p), .tx_serial(serial_p), .busy(busy_p),
        .complete(complete_p), .bit_count(count_p)
    );

    demo_serial_transmitter #(.DATA_BITS(8), .CLKS_PER_BIT(C), .PARITY_EN(0)) dut_np (
        .clk(clk), .reset(reset), .tx_valid(valid_np), .tx_data(tx_data),
        .tx_ready(ready_np), .tx_serial(serial_np), .busy(busy_np),
        .complete(complete_np), .bit_count(count_np)
    );

    assign o_ready    = sel ? ready_np    : ready_p;
    assign o_serial   = sel ? serial_np   : serial_p;
    assign o_busy     = sel ? busy_np     : busy_p;
    assign o_complete = sel ? complete_np : complete_p;
    assign o_count    = sel ? count_np    : count_p;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // seq bit i is the line value of bit period i (start first, stop last).
    task automatic run_frame(input logic s, input logic [7:0] data, input int nbits,
                             input logic [11:0] seq, input logic keep, input logic [7:0] next_data);
        sel     = s;
        tx_data = data;
        if (s) valid_np = 1'b1;
        else   valid_p  = 1'b1;
        for (int k = 0; k < nbits * C; k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (keep) tx_data = next_data;
                else begin
                    valid_p  = 1'b0;
                    valid_np = 1'b0;
                    tx_data  = ~data;
                end
            end
            chk($sformatf("line[%0d] data=%02h", k, data), 32'(o_serial), 32'(seq[k / C]));
            chk($sformatf("busy[%0d]", k), 32'(o_busy), 32'd1);
            chk($sformatf("ready[%0d]", k), 32'(o_ready), 32'd0);
            chk($sformatf("complete[%0d]", k), 32'(o_complete), 32'd0);
        end
        @(negedge clk);
        chk("end_complete", 32'(o_complete), 32'd1);
        chk("end_ready", 32'(o_ready), 32'd1);
        chk("end_busy", 32'(o_busy), 32'd0);
        chk("end_serial", 32'(o_serial), 32'd1);
        chk("end_bit_count", 32'(o_count), 32'd8);
        $display("[TB] frame dut=%s data=%02h clocks=%0d", s ? "np" : "p", data, nbits * C);
        if (!keep) begin
            @(negedge clk);
            chk("after_complete", 32'(o_complete), 32'd0);
        end
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 200 && !(ready_p && ready_np); i++) @(negedge clk);
        chk("idle_wait", 32'(ready_p && ready_np), 32'd1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_serial", 32'(serial_p), 32'd1);
        chk("rst_ready", 32'(ready_p), 32'd1);
        chk("rst_busy", 32'(busy_p), 32'd0);
        chk("rst_complete", 32'(complete_p), 32'd0);
        chk("rst_bit_count", 32'(count_p), 32'd0);
        chk("rst_np_serial", 32'(serial_np), 32'd1);
        reset = 1'b1;

        // Accept on the first edge after release: A5, parity 0
        run_frame(1'b0, 8'hA5, 11, 12'b0_1_0_10100101_0, 1'b0, 8'h00);
        wait_idle();

        // Odd weight: parity bit 1
        run_frame(1'b0, 8'h07, 11, 12'b0_1_1_00000111_0, 1'b0, 8'h00);
        wait_idle();

        // No parity: 40-clock frame
        run_frame(1'b1, 8'hFF, 10, 12'b00_1_11111111_0, 1'b0, 8'h00);
        wait_idle();

        // Back-to-back with tx_valid held; data changed while busy
        run_frame(1'b0, 8'h3C, 11, 12'b0_1_0_00111100_0, 1'b1, 8'hC3);
        run_frame(1'b0, 8'hC3, 11, 12'b0_1_0_11000011_0, 1'b0, 8'h00);
        wait_idle();

        // Asynchronous reset mid-DATA
        sel     = 1'b0;
        tx_data = 8'hA5;
        valid_p = 1'b1;
        @(negedge clk);
        valid_p = 1'b0;
        repeat (17) @(negedge clk);
        chk("mid_bit_count", 32'(count_p), 32'd3);
        chk("mid_serial_d3", 32'(serial_p), 32'd0);
        #2 reset = 1'b0;
        #1;
        chk("abort_serial", 32'(serial_p), 32'd1);
        chk("abort_ready", 32'(ready_p), 32'd1);
        chk("abort_bit_count", 32'(count_p), 32'd0);
        chk("abort_busy", 32'(busy_p), 32'd0);
        $display("[TB] reset asserted mid-frame");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("post_abort[%0d]", i), 32'({serial_p, ready_p, complete_p}), 32'b110);
        end
        run_frame(1'b0, 8'hA5, 11, 12'b0_1_0_10100101_0, 1'b0, 8'h00);

        // Reset and accept on the same edge: reset wins
        reset   = 1'b0;
        valid_p = 1'b1;
        tx_data = 8'h5A;
        @(negedge clk);
        chk("rst_accept_ready", 32'(ready_p), 32'd1);
        chk("rst_accept_serial", 32'(serial_p), 32'd1);
        chk("rst_accept_busy", 32'(busy_p), 32'd0);
        valid_p = 1'b0;
        reset   = 1'b1;
        $display("[TB] reset with tx_valid high");
        repeat (2) @(negedge clk);
        chk("rst_accept_idle", 32'(busy_p), 32'd0);

        // Long idle with tx_valid low
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk($sformatf("idle_p[%0d]", i), 32'({serial_p, ready_p, complete_p}), 32'b110);
            chk($sformatf("idle_np[%0d]", i), 32'({serial_np, ready_np, complete_np}), 32'b110);
        end
        $display("[TB] 100 idle cycles observed");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
